// File: rtl/i4001_rom_responder.sv
// ROM-chip end of the MCS-4 bus: follows the 8-phase cycle from SYNC/CLK2, returns
// the addressed instruction in M1/M2 and implements the 4001 SRC/WRR/RDR I/O port.
//
// phase | meaning
// A1    | address low nibble on bus
// A2    | address middle nibble on bus
// A3    | chip number on bus, CM-ROM qualifies
// M1    | instruction OPR driven by selected ROM
// M2    | instruction OPA driven, I/O op code seen
// X1    | execute, bus idle for this chip
// X2    | SRC chip number / WRR data / RDR read data
// X3    | SYNC high, end of cycle
module i4001_rom_responder #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       sysclk,
  input  logic       poc_pad,
  input  logic       clk1_pad,
  input  logic       clk2_pad,
  input  logic       sync_pad,
  input  logic       cmrom_pad,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_dir,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  output logic [2:0] phase,
  output logic       synced
);

  typedef enum logic [2:0] {
    PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
  } phase_e;

  phase_e     phase_q;
  logic       synced_q;
  logic       clk2_q;
  logic       enter_q;
  logic       load_addr_q;
  logic [3:0] addr_lo_q;
  logic [3:0] addr_hi_q;
  logic       rom_sel_q;
  logic       src_sel_q;
  logic       io_cycle_q;
  logic [3:0] opa_q;
  logic [3:0] io_out_q;
  logic [7:0] rom_addr_q;
  logic       data_dir_q;
  logic [3:0] data_out_q;

  logic       pe;
  logic       realign;
  logic       capture;
  logic       wrr_hit;
  logic [7:0] rom_addr_d;
  phase_e     phase_inc;

  // Clocks are non-overlapping, so clk1 is always low at a genuine clk2 fall.
  assign pe         = clk2_q & ~clk2_pad & ~clk1_pad;
  assign realign    = pe & sync_pad;
  assign capture    = pe & ~sync_pad & synced_q;
  assign wrr_hit    = io_cycle_q & (opa_q == 4'h2);
  assign rom_addr_d = {addr_hi_q, addr_lo_q};
  assign phase_inc  = phase_e'(phase_q + 3'd1);

  always_ff @(posedge sysclk or posedge poc_pad) begin
    if (poc_pad) begin
      phase_q     <= PH_X3;
      synced_q    <= 1'b0;
      clk2_q      <= 1'b0;
      enter_q     <= 1'b0;
      load_addr_q <= 1'b0;
      addr_lo_q   <= 4'h0;
      addr_hi_q   <= 4'h0;
      rom_sel_q   <= 1'b0;
      src_sel_q   <= 1'b0;
      io_cycle_q  <= 1'b0;
      opa_q       <= 4'h0;
      io_out_q    <= 4'h0;
      rom_addr_q  <= 8'h00;
      data_dir_q  <= 1'b0;
      data_out_q  <= 4'h0;
    end else begin
      clk2_q      <= clk2_pad;
      enter_q     <= pe;
      load_addr_q <= capture && (phase_q == PH_A3);
      if (load_addr_q) rom_addr_q <= rom_addr_d;

      if (realign) begin
        phase_q  <= PH_A1;
        synced_q <= 1'b1;
        // A SYNC outside X3 abandons whatever the aborted cycle had gathered.
        if (phase_q != PH_X3) begin
          addr_lo_q  <= 4'h0;
          addr_hi_q  <= 4'h0;
          io_cycle_q <= 1'b0;
        end
      end else if (pe) begin
        phase_q <= phase_inc;
        if (phase_q == PH_X3) synced_q <= 1'b0;
      end

      if (capture) begin
        case (phase_q)
          PH_A1: addr_lo_q <= data_in;
          PH_A2: addr_hi_q <= data_in;
          PH_A3: rom_sel_q <= cmrom_pad && (data_in == CHIP_ID);
          PH_M2: begin
            opa_q      <= data_in;
            io_cycle_q <= cmrom_pad & src_sel_q;
          end
          PH_X2: begin
            if (cmrom_pad) src_sel_q <= (data_in == CHIP_ID);
            if (wrr_hit) io_out_q <= data_in;
          end
          default: ;
        endcase
      end

      // Drive window opens one sysclk into the phase and always closes at its end.
      if (pe) begin
        data_dir_q <= 1'b0;
      end else if (enter_q && synced_q) begin
        case (phase_q)
          PH_M1: if (rom_sel_q) begin
            data_dir_q <= 1'b1;
            data_out_q <= rom_data[7:4];
          end
          PH_M2: if (rom_sel_q) begin
            data_dir_q <= 1'b1;
            data_out_q <= rom_data[3:0];
          end
          PH_X2: if (io_cycle_q && (opa_q == 4'hA)) begin
            data_dir_q <= 1'b1;
            data_out_q <= io_in;
          end
          default: ;
        endcase
      end
    end
  end

  assign phase    = phase_q;
  assign synced   = synced_q;
  assign data_dir = data_dir_q;
  assign data_out = data_out_q;
  assign rom_addr = rom_addr_q;
  assign io_out   = io_out_q;

endmodule

// File: tb/tb_i4001_rom_responder.sv
// Bench for i4001_rom_responder: phase-level reference model, a fetch vector table,
// hand sequences for SRC/WRR/RDR and bus disturbances, then randomized cycles.
module tb_i4001_rom_responder;
  localparam logic [3:0] CID = 4'h3;

  logic       sysclk = 1'b0;
  logic       poc_pad, clk1_pad, clk2_pad, sync_pad, cmrom_pad;
  logic [3:0] data_in, data_out, io_in, io_out;
  logic       data_dir, synced;
  logic [7:0] rom_addr, rom_data;
  logic [2:0] phase;

  i4001_rom_responder #(.CHIP_ID(CID)) dut (
    .sysclk(sysclk), .poc_pad(poc_pad), .clk1_pad(clk1_pad), .clk2_pad(clk2_pad),
    .sync_pad(sync_pad), .cmrom_pad(cmrom_pad), .data_in(data_in), .data_out(data_out),
    .data_dir(data_dir), .rom_addr(rom_addr), .rom_data(rom_data), .io_in(io_in),
    .io_out(io_out), .phase(phase), .synced(synced)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_pass   = 0;
  logic dir_seen;

  // Reference model state, advanced once per phase end.
  int         m_phase;
  logic       m_synced, m_rom_sel, m_src_sel, m_io_cycle, m_dir;
  logic [3:0] m_lo, m_hi, m_opa, m_io_out, m_dout;
  logic [7:0] m_rom_addr;

  typedef struct {
    logic       s;
    logic       cm;
    logic [3:0] d;
    int         ph;
    logic       dir;
    logic [3:0] dout;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic model_reset();
    m_phase = 7; m_synced = 0; m_rom_sel = 0; m_src_sel = 0; m_io_cycle = 0;
    m_dir = 0; m_lo = 0; m_hi = 0; m_opa = 0; m_io_out = 0; m_dout = 0; m_rom_addr = 0;
  endtask

  task automatic model_pe(input logic s, input logic cm, input logic [3:0] d);
    int   ended;
    logic wrr;
    ended = m_phase;
    if (s) begin
      if (ended != 7) begin
        m_lo = 0; m_hi = 0; m_io_cycle = 0;
      end
      m_phase  = 0;
      m_synced = 1;
    end else begin
      if (m_synced) begin
        case (ended)
          0: m_lo = d;
          1: m_hi = d;
          2: begin
            m_rom_sel  = cm && (d == CID);
            m_rom_addr = {m_hi, m_lo};
          end
          4: begin
            m_opa      = d;
            m_io_cycle = cm && m_src_sel;
          end
          6: begin
            wrr = m_io_cycle && (m_opa == 4'h2);
            if (cm) m_src_sel = (d == CID);
            if (wrr) m_io_out = d;
          end
          default: ;
        endcase
      end
      if (ended == 7) m_synced = 0;
      m_phase = (ended + 1) % 8;
    end
    m_dir = m_synced && ((((m_phase == 3) || (m_phase == 4)) && m_rom_sel) ||
                         ((m_phase == 6) && m_io_cycle && (m_opa == 4'hA)));
    if (m_dir) m_dout = (m_phase == 3) ? rom_data[7:4] : (m_phase == 4) ? rom_data[3:0] : io_in;
  endtask

  // One bus phase: inputs held across the clk2 fall, outputs checked once the
  // next phase's drive window has had its sysclk to open.
  task automatic run_phase(input logic s, input logic cm, input logic [3:0] d);
    sync_pad = s; cmrom_pad = cm; data_in = d;
    model_pe(s, cm, d);
    clk1_pad = 1; tick(); tick();
    clk1_pad = 0; tick();
    clk2_pad = 1; tick(); tick();
    clk2_pad = 0; tick(); tick();
    dir_seen = dir_seen | data_dir;
    chk("phase", int'(phase), m_phase);
    chk("synced", int'(synced), int'(m_synced));
    chk("data_dir", int'(data_dir), int'(m_dir));
    chk("data_out", int'(data_out), int'(m_dout));
    chk("io_out", int'(io_out), int'(m_io_out));
    chk("rom_addr", int'(rom_addr), int'(m_rom_addr));
  endtask

  task automatic run_cycle(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                           input logic cm3, input logic m2cm, input logic [3:0] m2d,
                           input logic x2cm, input logic [3:0] x2d, input logic x3s);
    run_phase(0, 0, a1);
    run_phase(0, 0, a2);
    run_phase(0, cm3, a3);
    run_phase(0, 0, 4'h0);
    run_phase(0, m2cm, m2d);
    run_phase(0, 0, 4'h0);
    run_phase(0, x2cm, x2d);
    run_phase(x3s, 0, 4'h0);
  endtask

  initial begin
    poc_pad = 1; clk1_pad = 0; clk2_pad = 0; sync_pad = 0; cmrom_pad = 0;
    data_in = 0; rom_data = 8'hD7; io_in = 4'h0; dir_seen = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_phase", int'(phase), 7);
    chk("rst_synced", int'(synced), 0);
    chk("rst_dir", int'(data_dir), 0);
    chk("rst_dout", int'(data_out), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_io_out", int'(io_out), 0);
    poc_pad = 0;
    tick();

    // Lock, then two clean cycles with no chip activity
    run_phase(1, 0, 4'h0);
    chk("lock_synced", int'(synced), 1);
    chk("lock_phase", int'(phase), 0);
    dir_seen = 0;
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < 8; p++) begin
        run_phase(p == 7, 0, 4'h0);
        chk("seq_phase", int'(phase), (p + 1) % 8);
      end
    chk("idle_no_drive", int'(dir_seen), 0);

    // Fetch miss: wrong chip number, address still latched
    dir_seen = 0;
    run_cycle(4'h5, 4'hA, 4'h2, 1, 0, 4'h0, 0, 4'h0, 1);
    chk("miss_no_drive", int'(dir_seen), 0);
    chk("miss_rom_addr", int'(rom_addr), 8'hA5);

    // Fetch hit via vector table
    vecs[0] = '{0, 0, 4'h5, 1, 0, 4'h0};
    vecs[1] = '{0, 0, 4'hA, 2, 0, 4'h0};
    vecs[2] = '{0, 1, 4'h3, 3, 1, 4'hD};
    vecs[3] = '{0, 0, 4'h0, 4, 1, 4'h7};
    vecs[4] = '{0, 0, 4'h0, 5, 0, 4'h7};
    vecs[5] = '{0, 0, 4'h0, 6, 0, 4'h7};
    vecs[6] = '{0, 0, 4'h0, 7, 0, 4'h7};
    vecs[7] = '{1, 0, 4'h0, 0, 0, 4'h7};
    for (int i = 0; i < 8; i++) begin
      run_phase(vecs[i].s, vecs[i].cm, vecs[i].d);
      chk("vec_phase", int'(phase), vecs[i].ph);
      chk("vec_dir", int'(data_dir), int'(vecs[i].dir));
      chk("vec_dout", int'(data_out), int'(vecs[i].dout));
    end
    chk("hit_rom_addr", int'(rom_addr), 8'hA5);

    // SRC select then WRR
    run_cycle(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 1, CID, 1);
    run_cycle(4'h0, 4'h0, 4'h0, 0, 1, 4'h2, 0, 4'h9, 1);
    chk("wrr_io_out", int'(io_out), 4'h9);
    // SRC to another chip, WRR must be ignored
    run_cycle(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 1, 4'h1, 1);
    run_cycle(4'h0, 4'h0, 4'h0, 0, 1, 4'h2, 0, 4'h5, 1);
    chk("wrr_desel_io_out", int'(io_out), 4'h9);

    // RDR
    run_cycle(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 1, CID, 1);
    io_in = 4'h6;
    run_phase(0, 0, 4'h0);
    run_phase(0, 0, 4'h0);
    run_phase(0, 0, 4'h0);
    run_phase(0, 0, 4'h0);
    run_phase(0, 1, 4'hA);
    chk("rdr_x1_dir", int'(data_dir), 0);
    run_phase(0, 0, 4'h0);
    chk("rdr_x2_dir", int'(data_dir), 1);
    chk("rdr_x2_dout", int'(data_out), 4'h6);
    run_phase(0, 0, 4'h0);
    chk("rdr_x3_dir", int'(data_dir), 0);
    run_phase(1, 0, 4'h0);

    // SYNC injected during an M1 drive
    run_phase(0, 0, 4'h5);
    run_phase(0, 0, 4'hA);
    run_phase(0, 1, CID);
    chk("inj_m1_dir", int'(data_dir), 1);
    run_phase(1, 0, 4'h0);
    chk("inj_phase", int'(phase), 0);
    chk("inj_dir", int'(data_dir), 0);
    chk("inj_io_out", int'(io_out), 4'h9);

    // SYNC withheld at X3
    run_cycle(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 0);
    chk("lost_synced", int'(synced), 0);
    run_phase(0, 0, 4'h0);
    run_phase(1, 0, 4'h0);
    chk("relock_synced", int'(synced), 1);

    // Power-on clear in the middle of an M2 drive
    run_phase(0, 0, 4'h5);
    run_phase(0, 0, 4'hA);
    run_phase(0, 1, CID);
    run_phase(0, 0, 4'h0);
    chk("poc_pre_dir", int'(data_dir), 1);
    #2 poc_pad = 1;
    #1;
    chk("poc_dir", int'(data_dir), 0);
    chk("poc_io_out", int'(io_out), 0);
    chk("poc_phase", int'(phase), 7);
    model_reset();
    tick(); tick();
    poc_pad = 0;
    tick();
    run_phase(1, 0, 4'h0);

    // Randomized cycles with occasional sync faults
    for (int it = 0; it < 60; it++) begin
      rom_data = 8'($urandom);
      io_in    = 4'($urandom);
      for (int p = 0; p < 8; p++) begin
        logic       s, cm;
        logic [3:0] d;
        s  = (p == 7) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0);
        cm = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
          0: d = CID;
          1: d = 4'h2;
          2: d = 4'hA;
          default: d = 4'($urandom);
        endcase
        run_phase(s, cm, d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/i4001_rom_responder.md
Name:
i4001_rom_responder

Overview:
- Peripheral-side (ROM-chip) end of the MCS-4 bus: tracks the 8-phase instruction cycle from SYNC and the two-phase clocks.
- Captures the 12-bit address the CPU drives in A1–A3, selects on chip number, and returns the 8-bit instruction in M1/M2.
- Implements the 4001 I/O port: SRC chip selection, WRR output latch, RDR input read.
- Sits opposite the CPU timing/I/O block on the shared 4-bit data bus; the bus pad tristate is resolved at the top level via data_in/data_out/data_dir.

Parameters:
- CHIP_ID, 4'h0, chip number matched against the A3 nibble and the SRC X2 nibble.

Ports:
- sysclk, input, 1, system clock; all logic sampled on posedge.
- poc_pad, input, 1, asynchronous active-high reset.
- clk1_pad, input, 1, phase clock 1 (level, sampled on sysclk).
- clk2_pad, input, 1, phase clock 2 (level, sampled on sysclk).
- sync_pad, input, 1, CPU SYNC; high during X3.
- cmrom_pad, input, 1, CPU CM-ROM line.
- data_in, input, 4, bus value seen at the pads.
- data_out, output, 4, value this chip drives.
- data_dir, output, 1, 1 = this chip drives the bus.
- rom_addr, output, 8, registered byte address to the ROM array.
- rom_data, input, 8, array read data; must be valid by M1 start.
- io_in, input, 4, I/O port input pins.
- io_out, output, 4, I/O port output latch.
- phase, output, 3, current phase: 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3.
- synced, output, 1, phase tracking is valid.

Behaviour:
- Reset (poc_pad high, asynchronous): phase=7, synced=0, rom_addr=0, io_out=0, data_out=0, data_dir=0; all internal latches (addr, rom_sel, src_sel, io_cycle, opa) cleared.
- Phase end event (pe): clk2_pad registered high on the previous sysclk and low now (clk2 falling edge, detected with a 1-sysclk delay register).
- Phase advance on each pe:
  - If sync_pad is sampled high at pe: phase <= 0 (A1) and synced <= 1.
  - Otherwise phase <= phase+1, wrapping 7->0.
  - If phase is 7 and no SYNC is seen at pe: synced <= 0 (lost lock).
  - While synced=0, data_dir=0 and no latches update, except SYNC detection.
- Bus captures, taken at pe only, while synced:
  - A1: addr_lo <= data_in.
  - A2: addr_hi <= data_in.
  - A3: rom_sel <= cmrom_pad && (data_in==CHIP_ID); rom_addr <= {addr_hi,addr_lo}, updating 1 sysclk after the A3 pe.
  - M2: opa <= data_in; io_cycle <= cmrom_pad && src_sel.
  - X2: if cmrom_pad is sampled high, this is an SRC: src_sel <= (data_in==CHIP_ID). If io_cycle && opa==4'h2 (WRR), io_out <= data_in. Both may occur in the same X2 only if the CPU asserts both; the SRC update and WRR use pre-pe src_sel/io_cycle values.
- Drive windows:
  - data_dir is registered; it asserts 1 sysclk after the pe that starts the phase and deasserts at the pe ending it.
  - M1 && rom_sel: data_out=rom_data[7:4].
  - M2 && rom_sel: data_out=rom_data[3:0].
  - X2 && io_cycle && opa==4'hA (RDR): data_out=io_in, sampled at X2 entry and held.
  - All other phases: data_dir=0, data_out holds its last value.
- Never drive during A1–A3 or X3. Never drive when synced=0.
- SYNC arriving mid-cycle (phase≠7) realigns to A1 immediately:
  - Partial address and io_cycle are discarded.
  - data_dir drops at that pe.
  - io_out and src_sel are kept.
- poc_pad asserted mid-drive: data_dir drops asynchronously the same instant.
- io_out changes only on a WRR X2 pe or on reset.

Test Plan:
- Reset/lock: hold poc_pad, release, run 2 full cycles with SYNC in X3 -> synced=1 after first SYNC pe; phase sequence 0..7 observed; data_dir=0 throughout A1–A3 and X3.
- Fetch hit (CHIP_ID=3): A1=4'h5, A2=4'hA, A3=4'h3 with cmrom=1, rom_data=8'hD7 -> rom_addr=8'hA5; data_dir=1 in M1 with data_out=4'hD, and in M2 with data_out=4'h7.
- Fetch miss: same stimulus with A3=4'h2 -> data_dir stays 0 all cycle; rom_addr still updates to 8'hA5.
- SRC+WRR: cycle N X2 cmrom=1 data=4'h3; cycle N+1 M2 cmrom=1 data=4'h2, X2 data=4'h9 -> io_out=4'h9 after the N+1 X2 pe. Repeat with SRC data=4'h1 -> io_out unchanged.
- RDR: selected via SRC, then M2 cmrom=1 data=4'hA, io_in=4'h6 -> data_dir=1 in X2 only, data_out=4'h6.
- Disturbances:
  - SYNC injected during M1 -> phase=0 next pe and data_dir drops.
  - SYNC withheld at X3 -> synced=0.
  - poc_pad pulsed during M2 drive -> data_dir=0 immediately and io_out=0.
